// File: rtl/control_unit.sv
// control_unit: multicycle fetch/decode/exec sequencer
// driving the regfile/ULA/memory datapath control port.
module control_unit #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       imem_data,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              enable,
  output logic [4:0]        a,
  output logic [4:0]        b,
  output logic [4:0]        w,
  output logic [63:0]       din,
  output logic              load_store,
  output logic              operation_type,
  output logic              ula_entry,
  output logic              op_ula,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_DONE,
    S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    K_ILL,
    K_LD,
    K_SD,
    K_ADDI,
    K_ADD,
    K_SUB,
    K_ECALL
  } kind_t;

  state_t state, state_nx;
  kind_t kind;

  logic [ADDR_W-1:0] pc;
  logic [31:0] ir;
  logic [31:0] inst;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [63:0] imm_i;
  logic [63:0] imm_s;

  // Decoder sees the incoming word in DECODE, the held word otherwise
  assign inst = (state == S_DECODE) ? imem_data : ir;

  assign opc = inst[6:0];
  assign rd  = inst[11:7];
  assign f3  = inst[14:12];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign f7  = inst[31:25];

  assign imm_i = {{52{inst[31]}}, inst[31:20]};
  assign imm_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};

  // Classify the instruction word
  always_comb begin
    kind = K_ILL;
    unique case (1'b1)
      (inst == 32'h0000_0073):
        kind = K_ECALL;
      (opc == 7'b0000011 && f3 == 3'b011):
        kind = K_LD;
      (opc == 7'b0100011 && f3 == 3'b011):
        kind = K_SD;
      (opc == 7'b0010011 && f3 == 3'b000):
        kind = K_ADDI;
      (opc == 7'b0110011 && f3 == 3'b000
        && f7 == 7'b0000000):
        kind = K_ADD;
      (opc == 7'b0110011 && f3 == 3'b000
        && f7 == 7'b0100000):
        kind = K_SUB;
      default:
        kind = K_ILL;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (start) state_nx = S_FETCH;
      S_FETCH:
        state_nx = S_DECODE;
      S_DECODE:
        unique case (kind)
          K_ECALL: state_nx = S_DONE;
          K_ILL:   state_nx = S_ERROR;
          default: state_nx = S_EXEC;
        endcase
      S_EXEC:
        state_nx = S_FETCH;
      default:
        state_nx = S_IDLE;
    endcase
  end

  // Program counter and instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_RESET;
      ir <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERROR:
          if (start) pc <= PC_RESET;
        S_DECODE:
          ir <= imem_data;
        S_EXEC:
          pc <= pc + ADDR_W'(4);
        default: ;
      endcase
    end
  end

  // Datapath control registers, loaded only by legal ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a              <= '0;
      b              <= '0;
      w              <= '0;
      din            <= '0;
      load_store     <= 1'b0;
      operation_type <= 1'b0;
      ula_entry      <= 1'b0;
      op_ula         <= 1'b1;
    end else if (state == S_DECODE) begin
      unique case (kind)
        K_LD: begin
          load_store     <= 1'b1;
          operation_type <= 1'b0;
          w              <= rd;
          b              <= rs1;
          din            <= imm_i;
        end
        K_SD: begin
          load_store     <= 1'b0;
          operation_type <= 1'b0;
          a              <= rs2;
          b              <= rs1;
          din            <= imm_s;
        end
        K_ADDI: begin
          load_store     <= 1'b1;
          operation_type <= 1'b1;
          ula_entry      <= 1'b0;
          op_ula         <= 1'b1;
          w              <= rd;
          b              <= rs1;
          din            <= imm_i;
        end
        K_ADD, K_SUB: begin
          load_store     <= 1'b1;
          operation_type <= 1'b1;
          ula_entry      <= 1'b1;
          op_ula         <= (kind == K_ADD);
          w              <= rd;
          b              <= rs1;
          a              <= rs2;
          din            <= '0;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc;
  assign enable    = (state == S_EXEC);
  assign busy      = (state == S_FETCH)
                   || (state == S_DECODE)
                   || (state == S_EXEC);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERROR);

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of the sequencer,
// plus a 4-bit pc instance for address wrap.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic start2;
  logic [31:0] imem_data;
  logic [31:0] imem_data2;
  logic [15:0] imem_addr;
  logic [3:0]  imem_addr2;
  logic enable, enable2;
  logic [4:0] a, b, w;
  logic [4:0] a2, b2, w2;
  logic [63:0] din, din2;
  logic load_store, load_store2;
  logic operation_type, operation_type2;
  logic ula_entry, ula_entry2;
  logic op_ula, op_ula2;
  logic busy, busy2;
  logic done, done2;
  logic error, error2;

  logic [31:0] imem [0:15];
  logic [31:0] imem2 [0:3];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= imem[imem_addr[5:2]];
  always @(posedge clk) imem_data2 <= imem2[imem_addr2[3:2]];

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_data(imem_data), .imem_addr(imem_addr),
    .enable(enable), .a(a), .b(b), .w(w), .din(din),
    .load_store(load_store),
    .operation_type(operation_type),
    .ula_entry(ula_entry), .op_ula(op_ula),
    .busy(busy), .done(done), .error(error)
  );

  control_unit #(.ADDR_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .imem_data(imem_data2), .imem_addr(imem_addr2),
    .enable(enable2), .a(a2), .b(b2), .w(w2), .din(din2),
    .load_store(load_store2),
    .operation_type(operation_type2),
    .ula_entry(ula_entry2), .op_ula(op_ula2),
    .busy(busy2), .done(done2), .error(error2)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clr_imem();
    for (int i = 0; i < 16; i++) imem[i] = 32'h0000_0073;
  endtask

  int en_cnt;
  int en_t [0:2];
  int ill_en;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    clr_imem();
    for (int i = 0; i < 4; i++) imem2[i] = 32'h0107_8893;
    step();
    step();

    chk("rst_enable", enable, 0);
    chk("rst_op_ula", op_ula, 1);
    chk("rst_addr", imem_addr, 0);
    chk("rst_din", din, 0);
    chk("rst_busy", {busy, done, error}, 0);
    chk("rst_wab", {w, a, b}, 0);
    chk("rst_ls_ot_ue", {load_store, operation_type, ula_entry}, 0);
    rst_n = 1'b1;
    step();

    // ADDI x15,x3,-85 then illegal word 0
    imem[0] = 32'hFAB1_8793;
    imem[1] = 32'h0000_0000;
    go();
    chk("addi_c1_busy", busy, 1);
    chk("addi_c1_en", enable, 0);
    step();
    chk("addi_c2_en", enable, 0);
    step();
    chk("addi_en", enable, 1);
    chk("addi_w", w, 15);
    chk("addi_b", b, 3);
    chk("addi_din", din, 64'hFFFF_FFFF_FFFF_FFAB);
    chk("addi_ot", operation_type, 1);
    chk("addi_ue", ula_entry, 0);
    chk("addi_op", op_ula, 1);
    chk("addi_ls", load_store, 1);
    step();
    chk("addi_next_addr", imem_addr, 4);
    chk("addi_next_en", enable, 0);
    step();
    step();
    chk("ill1_error", error, 1);
    chk("ill1_addr", imem_addr, 4);
    chk("ill1_hold_w", w, 15);

    // SD x4,2(x6) from ERROR
    clr_imem();
    imem[0] = 32'h0043_3123;
    go();
    chk("sd_err_clr", {error, busy}, 2'b01);
    chk("sd_addr0", imem_addr, 0);
    step();
    step();
    chk("sd_en", enable, 1);
    chk("sd_ls", load_store, 0);
    chk("sd_ot", operation_type, 0);
    chk("sd_a", a, 4);
    chk("sd_b", b, 6);
    chk("sd_din", din, 2);
    step();
    chk("sd_en_off", enable, 0);
    step();
    step();
    chk("sd_done", done, 1);

    // LD / SUB / ADDI / ECALL program
    clr_imem();
    imem[0] = 32'h0036_B103;
    imem[1] = 32'h4030_0933;
    imem[2] = 32'h0107_8893;
    imem[3] = 32'h0000_0073;
    en_cnt = 0;
    go();
    for (int c = 1; c <= 12; c++) begin
      if (enable) begin
        if (en_cnt < 3) en_t[en_cnt] = c;
        if (en_cnt == 0) begin
          chk("ld_w", w, 2);
          chk("ld_b", b, 13);
          chk("ld_din", din, 3);
          chk("ld_ls_ot", {load_store, operation_type}, 2'b10);
        end else if (en_cnt == 1) begin
          chk("sub_op", op_ula, 0);
          chk("sub_ue", ula_entry, 1);
          chk("sub_a", a, 3);
          chk("sub_b", b, 0);
          chk("sub_w", w, 18);
          chk("sub_din", din, 0);
        end else if (en_cnt == 2) begin
          chk("addi2_w", w, 17);
          chk("addi2_b", b, 15);
          chk("addi2_din", din, 16);
          chk("addi2_op_ue", {op_ula, ula_entry}, 2'b10);
        end
        en_cnt++;
      end
      if (c < 12) step();
    end
    chk("prog_en_cnt", en_cnt, 3);
    chk("prog_t0", en_t[0], 3);
    chk("prog_t1", en_t[1], 6);
    chk("prog_t2", en_t[2], 9);
    chk("prog_done", done, 1);
    chk("prog_busy", busy, 0);
    chk("prog_addr", imem_addr, 12);

    // illegal at address 0
    clr_imem();
    imem[0] = 32'h0000_007F;
    ill_en = 0;
    go();
    chk("ill_done_clr", done, 0);
    for (int c = 1; c <= 5; c++) begin
      if (enable) ill_en++;
      if (c < 5) step();
    end
    chk("ill_no_en", ill_en, 0);
    chk("ill_error", error, 1);
    chk("ill_addr", imem_addr, 0);
    chk("ill_hold_w", w, 17);
    imem[0] = 32'hFAB1_8793;
    imem[1] = 32'h0107_8893;
    go();
    chk("restart_err", {error, busy}, 2'b01);
    chk("restart_addr", imem_addr, 0);

    // start while busy is ignored, then reset in EXEC
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("busy_start_en", enable, 1);
    chk("busy_start_w", w, 15);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_addr", imem_addr, 4);
    step();
    step();
    chk("pre_rst_en", enable, 1);
    chk("pre_rst_w", w, 17);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_exec_en", enable, 0);
    chk("rst_exec_busy", busy, 0);
    chk("rst_exec_addr", imem_addr, 0);
    chk("rst_exec_op", op_ula, 1);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", {busy, done, error}, 0);

    // 4-bit pc wraps 12 -> 0
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c == 10) chk("wrap_addr12", imem_addr2, 12);
      if (c == 12) chk("wrap_en", enable2, 1);
      if (c < 13) step();
    end
    chk("wrap_addr0", imem_addr2, 0);
    chk("wrap_busy", busy2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
